// File: rtl/iiitb_alu_ctrl.sv
// rtl/iiitb_alu_ctrl.sv - command FIFO and issue/capture/response sequencer for the 4-bit ALU
module iiitb_alu_ctrl #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [M-1:0] cmd_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [M-1:0] alu_instr,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 2 * N + M;
  localparam logic [M-1:0] TRAP_OP = {1'b1, (M-1)'(3)};

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic [N-1:0]   alu_a_q, alu_b_q, rsp_data_q;
  logic [M-1:0]   alu_instr_q;
  logic           rsp_err_q;

  logic           push, pop, empty, take;
  logic           load_alu, load_trap, load_cap;
  logic [W-1:0]   head;
  logic [N-1:0]   head_a, head_b;
  logic [M-1:0]   head_op;
  logic           head_trap;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  assign head      = mem_q[rd_ptr_q];
  assign head_a    = head[W-1 -: N];
  assign head_b    = head[M+N-1 -: N];
  assign head_op   = head[M-1:0];
  assign head_trap = (head_op == TRAP_OP) && (head_b == '0);

  // A new head may be taken from IDLE, or straight out of RESP on the
  // handshake edge so back-to-back requests skip IDLE.
  assign take = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_alu  = 1'b0;
    load_trap = 1'b0;
    load_cap  = 1'b0;
    case (state_q)
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        load_cap = 1'b1;
        state_d  = RESP;
      end
      default: begin
        if (take) begin
          if (!empty) begin
            pop = 1'b1;
            if (head_trap) begin
              load_trap = 1'b1;
              state_d   = RESP;
            end else begin
              load_alu = 1'b1;
              state_d  = ISSUE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_instr_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Operands are held past ISSUE so the ALU output mux stays put during CAPTURE.
      if (load_alu) begin
        alu_a_q     <= head_a;
        alu_b_q     <= head_b;
        alu_instr_q <= head_op;
      end
      if (load_trap) begin
        rsp_data_q <= '1;
        rsp_err_q  <= 1'b1;
      end else if (load_cap) begin
        rsp_data_q <= alu_result;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_instr = alu_instr_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_iiitb_alu_ctrl.sv
// tb/tb_iiitb_alu_ctrl.sv - scoreboard bench for iiitb_alu_ctrl with a registered ALU model
module tb_iiitb_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
  logic [3:0] alu_a, alu_b, alu_instr;
  logic [3:0] alu_result = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int idle_cyc = 0;
  logic [4:0] exp_q [$];
  int         hs_q [$];

  iiitb_alu_ctrl #(.N(4), .M(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: one registered stage, N-bit truncating results.
  function automatic logic [3:0] alu_f(input logic [3:0] i, input logic [3:0] a, input logic [3:0] b);
    if (i[3]) begin
      case (i[2:0])
        3'd0: return a + b;
        3'd1: return a - b;
        3'd2: return a * b;
        3'd3: return (b == 0) ? 4'h0 : a / b;
        default: return 4'h0;
      endcase
    end else begin
      case (i[2:0])
        3'd0: return a & b;
        3'd1: return a | b;
        3'd2: return a ^ b;
        3'd3: return ~(a & b);
        3'd4: return ~(a | b);
        3'd5: return ~(a ^ b);
        3'd6: return ~a;
        default: return {3'b000, a == b};
      endcase
    end
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_instr, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {27'd0, rsp_err, rsp_data}, 32'hFFFF_FFFF);
      end else begin
        check("rsp", {27'd0, rsp_err, rsp_data}, {27'd0, exp_q.pop_front()});
      end
      hs_q.push_back(cyc);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(exp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("idle_timeout", 32'd0, 32'd1);
    idle_cyc = cyc;
    @(posedge clk); #1;
  endtask

  logic [3:0] bp_op [6] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'hA, 4'h8};
  logic [3:0] bp_a  [6] = '{4'd1, 4'd2, 4'd7, 4'd15, 4'd4, 4'd3};
  logic [3:0] bp_b  [6] = '{4'd1, 4'd3, 4'd7, 4'd1, 4'd5, 4'd3};
  logic [4:0] bp_e  [6] = '{5'h02, 5'h05, 5'h0E, 5'h00, 5'h04, 5'h06};

  initial begin
    int acc;
    int base;
    #1 reset = 1'b1;
    #3;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_data", {rsp_err, rsp_data}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // ADD with latency: accepted at E0, valid after E3.
    send(4'h8, 4'd3, 4'd5, 5'h08);
    repeat (3) @(negedge clk);
    check("add_lat_e2", rsp_valid, 0);
    @(negedge clk);
    check("add_lat_e3", rsp_valid, 1);
    @(posedge clk); #1;
    send(4'h8, 4'd9, 4'd9, 5'h02);
    wait_idle();

    // Logical ops, order preserved.
    send(4'h0, 4'hC, 4'hA, 5'h08);
    send(4'h7, 4'h5, 4'h5, 5'h01);
    wait_idle();

    // Divide-by-zero trap: valid one cycle after pop, ALU registers untouched.
    send(4'hB, 4'd7, 4'd0, 5'h1F);
    @(negedge clk);
    check("trap_lat_e0", rsp_valid, 0);
    @(negedge clk);
    check("trap_lat_e1", rsp_valid, 1);
    check("trap_alu_instr", alu_instr, 4'h7);
    check("trap_alu_a", alu_a, 4'h5);
    check("trap_alu_b", alu_b, 4'h5);
    wait_idle();
    send(4'hB, 4'd8, 4'd2, 5'h04);
    wait_idle();

    // Backpressure: DEPTH+1 accepted before cmd_ready drops.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = bp_op[i]; cmd_a = bp_a[i]; cmd_b = bp_b[i];
      @(negedge clk);
      if (cmd_ready) begin
        acc++;
        exp_q.push_back(bp_e[i]);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("bp_accepted", acc, 5);
    @(negedge clk);
    check("bp_cmd_ready_low", cmd_ready, 0);
    check("bp_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_idle();
    check("bp_cmd_ready_high", cmd_ready, 1);

    // Back-to-back: results every 3 cycles, busy drops right after the last handshake.
    base = hs_q.size();
    send(4'h8, 4'd1, 4'd2, 5'h03);
    send(4'h8, 4'd4, 4'd4, 5'h08);
    send(4'h8, 4'd8, 4'd8, 5'h00);
    send(4'h8, 4'd7, 4'd6, 5'h0D);
    wait_idle();
    check("b2b_count", hs_q.size() - base, 4);
    if (hs_q.size() - base == 4) begin
      for (int i = 1; i < 4; i++) check("b2b_spacing", hs_q[base+i] - hs_q[base+i-1], 3);
      check("b2b_busy_fall", idle_cyc, hs_q[base+3] + 1);
    end

    // Asynchronous reset mid-operation.
    rsp_ready = 1'b0;
    send(4'h8, 4'd2, 4'd2, 5'h04);
    send(4'h8, 4'd3, 4'd3, 5'h06);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_rsp_err", rsp_err, 0);
    check("mid_rst_alu_instr", alu_instr, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(4'h8, 4'd1, 4'd2, 5'h03);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iiitb_alu_ctrl.md
# iiitb_alu_ctrl

Command-side controller for the 4-bit ALU. Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. Issues each request to the ALU, holding operands and instruction stable across the ALU's one-cycle registered latency, then returns the captured result over a second valid/ready handshake. Divide-by-zero requests are trapped and never issued to the ALU.

## Interface
- N, 4: operand/result width
- M, 4: instruction width; instruction[M-1]=1 selects arithmetic, 0 selects logical; instruction[M-2:0] is the sub-op
- DEPTH, 4: command FIFO depth; power of two, ≥2
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- cmd_valid  input  1  request present
- cmd_ready  output  1  request accepted on an edge where cmd_valid && cmd_ready
- cmd_a, cmd_b  input  N  operands
- cmd_op  input  M  ALU instruction
- alu_a, alu_b  output  N  registered operands to the ALU
- alu_instr  output  M  registered instruction to the ALU
- alu_result  input  N  ALU result (ALU_out)
- rsp_valid  output  1  result available
- rsp_ready  input  1  result consumed on an edge where rsp_valid && rsp_ready
- rsp_data  output  N  result
- rsp_err  output  1  1 = divide-by-zero trap; rsp_data = all ones
- busy  output  1  state != IDLE or FIFO non-empty

## Operation
- FIFO: DEPTH×(2N+M), with read/write pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits. cmd_ready = (count != DEPTH), combinational from registers.
- When full, a push is refused even if a pop happens on the same edge (no pass-through). Simultaneous push and pop when not full leaves count unchanged.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if FIFO non-empty, pop the head.
  - Normal request: load alu_a/alu_b/alu_instr from the head, go to ISSUE.
  - Trap request (cmd_op == {1'b1, 3'h3} and cmd_b == 0): do not touch alu_* registers; set rsp_data = {N{1'b1}}, rsp_err = 1; go to RESP.
- ISSUE: unconditional transition to CAPTURE. The ALU sub-units register on this edge.
- CAPTURE: rsp_data <= alu_result, rsp_err <= 0; go to RESP.
- RESP: rsp_valid = 1. On a handshake edge:
  - FIFO non-empty: pop and branch exactly as in IDLE (ISSUE or trap-RESP).
  - FIFO empty: go to IDLE.
- rsp_valid, rsp_data and rsp_err are stable while waiting for rsp_ready.
- alu_a/alu_b/alu_instr hold their last value until the next non-trap pop, so alu_instr[M-1] stays stable through the ALU output mux during CAPTURE.
- Results follow ALU N-bit truncation, e.g. 9+9 → 2, 4*5 → 4. The controller adds no width extension.
- Responses return strictly in acceptance order.

## Timing
- Reset values: cmd_ready 1, alu_a/alu_b/alu_instr 0, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, FSM in IDLE, FIFO empty.
- Normal latency: command accepted at edge E0, popped at E1, ALU registers at E2, captured at E3; rsp_valid is high after E3 (3 cycles).
- Trap latency: popped at E1; rsp_valid is high after E1.
- Throughput with rsp_ready held high: one normal result per 3 cycles. RESP→ISSUE skips IDLE.
- With rsp_ready low from the start, the first request leaves the FIFO at E1, so DEPTH+1 requests are accepted before cmd_ready drops.
- Reset asserted mid-operation (any state): all outputs return to reset values asynchronously. The in-flight request and all FIFO contents are discarded. Operation resumes on the first edge after deassertion.
- A request arriving while the FIFO is empty and the FSM is in RESP is pushed first and popped no earlier than the next edge.

## Test plan
- Reset: assert reset mid-stream → cmd_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, alu_instr 0, busy 0 without waiting for a clock edge.
- ADD: cmd_op 4'h8, a=3, b=5, rsp_ready=1 → rsp_valid rises 3 cycles after acceptance, rsp_data 8, rsp_err 0. Also a=9, b=9 → rsp_data 2.
- Logical: cmd_op 4'h0, a=4'hC, b=4'hA → rsp_data 4'h8. Then cmd_op 4'h7, a=b=5 → rsp_data 1. Order preserved.
- Trap: cmd_op 4'hB, a=7, b=0 → rsp_valid 1 cycle after pop, rsp_data 4'hF, rsp_err 1, alu_* unchanged. A following 4'hB with a=8, b=2 → rsp_data 4, rsp_err 0.
- Backpressure: rsp_ready=0, stream 6 requests → exactly 5 accepted, cmd_ready low. Release rsp_ready → 5 responses in order, then cmd_ready returns high.
- Back-to-back: 4 queued ADDs with rsp_ready=1 → rsp_valid pulses spaced 3 cycles apart, busy falls after the last handshake.
